recon_stream: RTL and testbench
===============================

# recon_stream

Output stage of the 3×3 binary-pixel VAE decoder. Accepts one frame of nine signed Q4.16 sigmoid probabilities together with the original 9-bit input pixel vector. Thresholds, clamps and compares each pixel, then streams the reconstruction one pixel per beat over a valid/ready interface. Also keeps per-frame mismatch and frame-count statistics for the host-side readout.

## Interface
Parameters:
- N_PIX, 9, pixels per frame (3×3)
- W, 20, probability word width, signed Q4.16
- THRESH, 20'sh08000, binarisation threshold (0.5 in Q4.16)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  frame available on in_prob/in_pix
- in_ready  out  1  block can capture a frame
- in_pix  in  N_PIX  original binary pixels, bit i = pixel i
- in_prob  in  N_PIX*W  packed probabilities, pixel i at [i*W +: W]
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_idx  out  4  pixel index 0..8
- out_bit  out  1  reconstructed pixel (prob >= THRESH)
- out_prob  out  16  clamped probability, unsigned Q0.16
- out_err  out  1  out_bit != original pixel
- out_last  out  1  beat is pixel 8
- frame_err  out  4  total mismatches in current frame, 0..9, stable for the whole frame
- frame_cnt  out  16  completed frames, wraps at 0xFFFF→0

## Operation
- FSM states: IDLE, STREAM.
- IDLE: in_ready=1, out_valid=0. On in_valid, the frame is captured into registers:
  - probabilities
  - pixel vector
  - mismatch vector
  - popcount → frame_err
  - beat index cleared to 0
  - state → STREAM
- STREAM: in_ready=0, out_valid=1, outputs driven from the captured registers at the current index.
  - On out_valid&&out_ready with idx<8: idx+1.
  - With idx==8: frame_cnt+1, state → IDLE.
- Backpressure: while out_valid=1 and out_ready=0, all out_* hold stable.
- Threshold compare: signed compare of the raw W-bit word against THRESH, before clamping.
- Clamp:
  - raw<0 → 0x0000
  - raw>=0x10000 → 0xFFFF
  - else raw[15:0]
- in_valid while in STREAM is ignored; the upstream source holds it, per the valid/ready contract.
- rst in any state:
  - state=IDLE
  - out_valid=0, in_ready=1 on the following cycle
  - idx=0, frame_err=0, frame_cnt=0
  - any partially streamed frame is discarded

## Timing
- Reset values: out_valid=0, out_idx=0, out_bit=0, out_prob=0, out_err=0, out_last=0, frame_err=0, frame_cnt=0. in_ready=1 once out of reset.
- Latency: frame captured at edge t; pixel 0 visible with out_valid=1 after edge t (cycle t+1).
- With out_ready tied high, one frame takes 9 beats plus 1 IDLE bubble, so throughput is 1 frame per 10 cycles.
- All out_* are registered; in_ready is a decode of the registered state. There is no combinational path from in_* or out_ready to any output.
- frame_cnt updates on the edge that accepts the last beat. It shows the new value in the cycle IDLE is re-entered.

## Structure
- Shared package recon_pkg holds:
  - N_PIX, W, FRAC=16
  - ONE_Q=20'sh10000
  - THRESH_HALF=20'sh08000
  - state enum {IDLE, STREAM}
- The same package constants serve the decoder's other fixed-point blocks.
- One sub-module: prob_clamp (combinational: signed Q4.16 in, unsigned Q0.16 out, plus the threshold bit). It is instantiated once on the muxed current-pixel word.
- Popcount of the 9-bit mismatch vector is a small inline function in the package.

## Test plan
- Reset then idle: rst 2 cycles → out_valid=0, in_ready=1, frame_cnt=0, frame_err=0.
- Perfect frame: in_pix=9'b101010101; probs alternating 0x0E000 / 0x02000 matching the pixels; out_ready=1 → 9 beats, idx 0..8, out_bit matches in_pix, out_err=0, frame_err=0, out_last only at idx 8, frame_cnt=1.
- Clamp/threshold edges:
  - prob 0xFFF00 (negative) → out_prob=0x0000, bit 0
  - 0x08000 → bit 1
  - 0x07FFF → bit 0
  - 0x14000 → out_prob=0xFFFF, bit 1
- Mismatch count: in_pix=9'h000, all probs 0x0C000 → every out_err=1, frame_err=9 from beat 0.
- Backpressure: out_ready low for 3 cycles at idx 4 → outputs frozen at idx 4. in_valid asserted in STREAM is not captured; after the frame, the next frame starts one bubble cycle later.
- Reset mid-stream and counter wrap:
  - rst at idx 5 → out_valid=0 next cycle, frame_cnt=0, new frame restarts at idx 0.
  - frame_cnt preloaded via 65536 frames (or a force) wraps 0xFFFF→0x0000.

Source files
------------

// File: rtl/recon_pkg.sv
// Shared fixed-point constants and types for the VAE decoder blocks.
// Probabilities are signed Q4.16; pixels are single bits.
package recon_pkg;

  localparam int N_PIX = 9;
  localparam int W     = 20;
  localparam int FRAC  = 16;

  localparam logic signed [19:0] ONE_Q       = 20'sh10000;
  localparam logic signed [19:0] THRESH_HALF = 20'sh08000;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/prob_clamp.sv
// Binarise and clamp one signed Q4.16 probability.
// The threshold bit is taken from the raw word, before clamping.
module prob_clamp
  import recon_pkg::*;
#(
  parameter int W = 20,
  parameter logic signed [W-1:0] THRESH = 20'sh08000
) (
  input  logic signed [W-1:0] raw,
  output logic [15:0]         prob,
  output logic                bin
);

  always_comb begin
    bin  = (raw >= THRESH);
    prob = raw[FRAC-1:0];
    if (raw[W-1]) begin
      prob = 16'h0000;
    end else if (raw >= ONE_Q) begin
      prob = 16'hFFFF;
    end
  end

endmodule

// File: rtl/recon_stream.sv
// Decoder output stage: captures a 3x3 probability frame and streams
// the thresholded reconstruction one pixel per beat.
module recon_stream
  import recon_pkg::*;
#(
  parameter int N_PIX = 9,
  parameter int W = 20,
  parameter logic signed [W-1:0] THRESH = THRESH_HALF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_PIX-1:0]   in_pix,
  input  logic [N_PIX*W-1:0] in_prob,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_idx,
  output logic               out_bit,
  output logic [15:0]        out_prob,
  output logic               out_err,
  output logic               out_last,
  output logic [3:0]         frame_err,
  output logic [15:0]        frame_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(N_PIX - 1);

  state_t state_q;
  state_t state_d;

  logic signed [W-1:0] prob_q [N_PIX];
  logic [N_PIX-1:0]    pix_q;
  logic [3:0]          idx_q;
  logic [3:0]          nxt_idx;

  logic                capture;
  logic                advance;
  logic                last;
  logic [N_PIX-1:0]    mis;
  logic signed [W-1:0] sel_word;
  logic                sel_pix;
  logic                c_bin;
  logic [15:0]         c_prob;

  assign in_ready = (state_q == IDLE);
  assign capture  = in_ready && in_valid;
  assign advance  = (state_q == STREAM) && out_ready;
  assign last     = (idx_q == LAST_IDX);
  assign nxt_idx  = last ? 4'd0 : idx_q + 4'd1;

  always_comb begin
    mis = '0;
    for (int i = 0; i < N_PIX; i++) begin
      mis[i] = ($signed(in_prob[i*W +: W]) >= THRESH) ^ in_pix[i];
    end
  end

  // The one clamp sees pixel 0 of the incoming frame while idle,
  // otherwise the pixel about to become current.
  always_comb begin
    sel_word = prob_q[nxt_idx];
    sel_pix  = pix_q[nxt_idx];
    if (in_ready) begin
      sel_word = in_prob[W-1:0];
      sel_pix  = in_pix[0];
    end
  end

  prob_clamp #(
    .W      (W),
    .THRESH (THRESH)
  ) u_clamp (
    .raw  (sel_word),
    .prob (c_prob),
    .bin  (c_bin)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = STREAM;
      STREAM:  if (out_ready && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PIX; i++) begin
        prob_q[i] <= '0;
      end
      pix_q     <= '0;
      idx_q     <= '0;
      frame_err <= '0;
      frame_cnt <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_bit   <= 1'b0;
      out_prob  <= '0;
      out_err   <= 1'b0;
      out_last  <= 1'b0;
    end else if (capture) begin
      for (int i = 0; i < N_PIX; i++) begin
        prob_q[i] <= in_prob[i*W +: W];
      end
      pix_q     <= in_pix;
      idx_q     <= '0;
      frame_err <= popcount9(mis);
      out_valid <= 1'b1;
      out_idx   <= '0;
      out_bit   <= c_bin;
      out_prob  <= c_prob;
      out_err   <= c_bin ^ sel_pix;
      out_last  <= 1'b0;
    end else if (advance) begin
      if (last) begin
        idx_q     <= '0;
        frame_cnt <= frame_cnt + 16'd1;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        idx_q    <= nxt_idx;
        out_idx  <= nxt_idx;
        out_bit  <= c_bin;
        out_prob <= c_prob;
        out_err  <= c_bin ^ sel_pix;
        out_last <= (nxt_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_recon_stream.sv
// Directed and randomised frames against a per-pixel arithmetic model.
// Covers reset, thresholds, clamps, backpressure, abort and wrap.
module tb_recon_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   in_pix;
  logic [179:0] in_prob;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_idx;
  logic         out_bit;
  logic [15:0]  out_prob;
  logic         out_err;
  logic         out_last;
  logic [3:0]   frame_err;
  logic [15:0]  frame_cnt;

  int checks = 0;
  int failures = 0;

  int          cur_p [9];
  logic [8:0]  cur_pix;
  logic [15:0] m_cnt;
  int          m_ferr;

  logic [19:0] edge_v [9] = '{20'hFFF00, 20'h08000, 20'h07FFF,
                              20'h14000, 20'h80000, 20'h7FFFF,
                              20'h10000, 20'h0FFFF, 20'h00000};

  always #5 clk = ~clk;

  recon_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_prob   (in_prob),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_bit   (out_bit),
    .out_prob  (out_prob),
    .out_err   (out_err),
    .out_last  (out_last),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [19:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic m_bit(input int p);
    return (p >= 32768);
  endfunction

  function automatic logic [15:0] m_prob(input int p);
    if (p < 0) return 16'h0000;
    if (p >= 65536) return 16'hFFFF;
    return p[15:0];
  endfunction

  function automatic logic [179:0] pack_frame();
    logic [179:0] v;
    logic [31:0] t;
    v = '0;
    for (int i = 0; i < 9; i++) begin
      t = cur_p[i];
      v[i*20 +: 20] = t[19:0];
    end
    return v;
  endfunction

  task automatic check_beat(input int i);
    logic e;
    e = m_bit(cur_p[i]) ^ cur_pix[i];
    chk($sformatf("valid[%0d]", i), out_valid, 1);
    chk($sformatf("idx[%0d]", i), out_idx, i);
    chk($sformatf("bit[%0d]", i), out_bit, m_bit(cur_p[i]));
    chk($sformatf("prob[%0d]", i), out_prob, m_prob(cur_p[i]));
    chk($sformatf("err[%0d]", i), out_err, e);
    chk($sformatf("last[%0d]", i), out_last, (i == 8));
    chk($sformatf("ferr[%0d]", i), frame_err, m_ferr);
    chk($sformatf("busy[%0d]", i), in_ready, 0);
  endtask

  // Entered and left just after a falling edge.
  task automatic run_frame(input int stall_at, input int stall_n,
                           input int abort_at, input bit rnd);
    int n;
    m_ferr = 0;
    for (int i = 0; i < 9; i++) begin
      m_ferr += int'(m_bit(cur_p[i]) ^ cur_pix[i]);
    end
    chk("idle_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_pix    = cur_pix;
    in_prob   = pack_frame();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_pix   = ~cur_pix;
    in_prob  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 9; i++) begin
      check_beat(i);
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 16'h0000;
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_cnt", frame_cnt, m_cnt);
        chk("abort_ferr", frame_err, 0);
        chk("abort_idx", out_idx, 0);
        return;
      end
      n = (i == stall_at) ? stall_n : (rnd ? $urandom_range(0, 2) : 0);
      if (n > 0) begin
        out_ready = 1'b0;
        in_valid  = (i == stall_at);
        repeat (n) begin
          @(negedge clk);
          check_beat(i);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    m_cnt = m_cnt + 16'd1;
    chk("end_valid", out_valid, 0);
    chk("end_ready", in_ready, 1);
    chk("end_cnt", frame_cnt, m_cnt);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pix    = '0;
    in_prob   = '0;
    out_ready = 1'b0;
    m_cnt     = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_bit", out_bit, 0);
    chk("rst_prob", out_prob, 0);
    chk("rst_err", out_err, 0);
    chk("rst_last", out_last, 0);

    cur_pix = 9'b101010101;
    for (int i = 0; i < 9; i++) begin
      cur_p[i] = cur_pix[i] ? sx(20'h0E000) : sx(20'h02000);
    end
    run_frame(-1, 0, -1, 1'b0);

    cur_pix = 9'b011001110;
    for (int i = 0; i < 9; i++) cur_p[i] = sx(edge_v[i]);
    run_frame(-1, 0, -1, 1'b0);

    cur_pix = 9'h000;
    for (int i = 0; i < 9; i++) cur_p[i] = sx(20'h0C000);
    run_frame(-1, 0, -1, 1'b0);

    cur_pix = 9'h0F3;
    for (int i = 0; i < 9; i++) cur_p[i] = sx(20'($urandom));
    run_frame(4, 3, -1, 1'b0);

    cur_pix = 9'h155;
    for (int i = 0; i < 9; i++) cur_p[i] = sx(20'($urandom));
    run_frame(-1, 0, 5, 1'b0);

    cur_pix = 9'h1C7;
    for (int i = 0; i < 9; i++) cur_p[i] = sx(20'($urandom));
    run_frame(-1, 0, -1, 1'b0);

    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    m_cnt = 16'hFFFF;
    chk("preload_cnt", frame_cnt, m_cnt);
    cur_pix = 9'($urandom);
    for (int i = 0; i < 9; i++) cur_p[i] = sx(20'($urandom));
    run_frame(-1, 0, -1, 1'b0);
    chk("wrap_cnt", frame_cnt, 16'h0000);

    for (int f = 0; f < 10; f++) begin
      cur_pix = 9'($urandom);
      for (int i = 0; i < 9; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          cur_p[i] = 32768 + $urandom_range(0, 4) - 2;
        end else begin
          cur_p[i] = sx(20'($urandom));
        end
      end
      run_frame(-1, 0, -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
